// File: rtl/ttt_move_arbiter.sv
// Tic-tac-toe move arbiter: owns the 3x3 board, alternates turns between X and O,
// accepts or rejects moves, enforces an optional per-turn timeout and reports win/draw.
module ttt_move_arbiter #(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int FIRST_PLAYER   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       req_x,
   input  logic [3:0] cell_x,
   input  logic       req_o,
   input  logic [3:0] cell_o,
   output logic       grant_x,
   output logic       grant_o,
   output logic       reject,
   output logic       timeout,
   output logic [8:0] board_x,
   output logic [8:0] board_o,
   output logic       turn,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TIMER_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMER_LAST_I);
   localparam logic FIRST_IS_O = (FIRST_PLAYER != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TURN_X,
      S_TURN_O,
      S_CHECK,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [8:0]    board_x_q, board_x_d;
   logic [8:0]    board_o_q, board_o_d;
   logic [1:0]    winner_q, winner_d;
   logic [3:0]    count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          turn_q, turn_d;
   logic          game_over_q, game_over_d;
   logic          grant_x_q, grant_x_d;
   logic          grant_o_q, grant_o_d;
   logic          reject_q, reject_d;
   logic          timeout_q, timeout_d;

   logic          mover_is_o;
   logic          act_req;
   logic [3:0]    act_cell;
   logic [15:0]   occupied;
   logic [8:0]    cell_mask;
   logic          legal;
   logic          expired;
   logic [8:0]    mover_board;

   // Three rows, three columns and both diagonals.
   function automatic logic has_line(input logic [8:0] b);
      has_line = (&b[2:0]) | (&b[5:3]) | (&b[8:6])
               | (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8])
               | (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
   endfunction

   always_comb begin
      state_d     = state_q;
      board_x_d   = board_x_q;
      board_o_d   = board_o_q;
      winner_d    = winner_q;
      count_d     = count_q;
      timer_d     = timer_q;
      turn_d      = turn_q;
      grant_x_d   = 1'b0;
      grant_o_d   = 1'b0;
      reject_d    = 1'b0;
      timeout_d   = 1'b0;

      mover_is_o  = (state_q == S_TURN_O);
      act_req     = mover_is_o ? req_o : req_x;
      act_cell    = mover_is_o ? cell_o : cell_x;
      // Padded to 16 bits so an out-of-range cell index never reads past the board.
      occupied    = {7'b0, board_x_q | board_o_q};
      cell_mask   = 9'b1 << act_cell;
      legal       = act_req && (act_cell <= 4'd8) && !occupied[act_cell];
      expired     = (TIMEOUT_CYCLES > 0) && (timer_q == TIMER_LAST);
      mover_board = turn_q ? board_o_q : board_x_q;

      if (start) begin
         board_x_d = '0;
         board_o_d = '0;
         winner_d  = 2'b00;
         count_d   = '0;
         timer_d   = '0;
         state_d   = FIRST_IS_O ? S_TURN_O : S_TURN_X;
      end else begin
         case (state_q)
            S_TURN_X, S_TURN_O: begin
               if (legal) begin
                  if (mover_is_o) begin
                     board_o_d = board_o_q | cell_mask;
                     grant_o_d = 1'b1;
                  end else begin
                     board_x_d = board_x_q | cell_mask;
                     grant_x_d = 1'b1;
                  end
                  count_d = count_q + 4'd1;
                  state_d = S_CHECK;
               end else if (expired) begin
                  timeout_d = 1'b1;
                  timer_d   = '0;
                  state_d   = mover_is_o ? S_TURN_X : S_TURN_O;
               end else begin
                  reject_d = act_req;
                  if (TIMEOUT_CYCLES > 0) begin
                     timer_d = timer_q + TW'(1);
                  end
               end
            end
            S_CHECK: begin
               // turn_q still names the player who just moved.
               if (has_line(mover_board)) begin
                  winner_d = turn_q ? 2'b10 : 2'b01;
                  state_d  = S_DONE;
               end else if (count_q == 4'd9) begin
                  winner_d = 2'b11;
                  state_d  = S_DONE;
               end else begin
                  timer_d = '0;
                  state_d = turn_q ? S_TURN_X : S_TURN_O;
               end
            end
            default: begin
            end
         endcase
      end

      if (state_d == S_TURN_X) begin
         turn_d = 1'b0;
      end else if (state_d == S_TURN_O) begin
         turn_d = 1'b1;
      end
      game_over_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         board_x_q   <= '0;
         board_o_q   <= '0;
         winner_q    <= 2'b00;
         count_q     <= '0;
         timer_q     <= '0;
         turn_q      <= 1'b0;
         game_over_q <= 1'b0;
         grant_x_q   <= 1'b0;
         grant_o_q   <= 1'b0;
         reject_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         board_x_q   <= board_x_d;
         board_o_q   <= board_o_d;
         winner_q    <= winner_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         turn_q      <= turn_d;
         game_over_q <= game_over_d;
         grant_x_q   <= grant_x_d;
         grant_o_q   <= grant_o_d;
         reject_q    <= reject_d;
         timeout_q   <= timeout_d;
      end
   end

   assign grant_x   = grant_x_q;
   assign grant_o   = grant_o_q;
   assign reject    = reject_q;
   assign timeout   = timeout_q;
   assign board_x   = board_x_q;
   assign board_o   = board_o_q;
   assign turn      = turn_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule

// File: tb/tb_ttt_move_arbiter.sv
// Bench for ttt_move_arbiter: scripted games plus random play, checked against a
// game-level model through an event scoreboard and per-cycle board snapshots.
module tb_ttt_move_arbiter;

   localparam int TO_CYC = 8;
   localparam int FIRST  = 0;

   logic       clk = 1'b0;
   logic       reset, start, req_x, req_o;
   logic [3:0] cell_x, cell_o;
   logic       grant_x, grant_o, reject, timeout, turn, game_over;
   logic [8:0] board_x, board_o;
   logic [1:0] winner;

   ttt_move_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .FIRST_PLAYER(FIRST)) dut (
      .clk(clk), .reset(reset), .start(start),
      .req_x(req_x), .cell_x(cell_x), .req_o(req_o), .cell_o(cell_o),
      .grant_x(grant_x), .grant_o(grant_o), .reject(reject), .timeout(timeout),
      .board_x(board_x), .board_o(board_o), .turn(turn),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   typedef enum int {EV_GX, EV_GO, EV_REJ, EV_TO, EV_END} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [8:0] bx;
      logic [8:0] bo;
      logic [1:0] win;
      logic       trn;
   } ev_t;
   ev_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Game-level model: cells hold 0 empty, 1 X, 2 O.
   typedef enum int {M_IDLE, M_PLAY, M_EVAL, M_DONE} mode_t;
   mode_t      m_mode;
   int         cells[9];
   int         m_player, m_moves, m_waited;
   logic [1:0] m_winner;
   logic       m_turn;
   int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic logic [8:0] mboard(int who);
      logic [8:0] b;
      for (int n = 0; n < 9; n++) b[n] = (cells[n] == who);
      return b;
   endfunction

   function automatic bit mwins(int who);
      for (int l = 0; l < 8; l++)
         if (cells[lines[l][0]] == who && cells[lines[l][1]] == who && cells[lines[l][2]] == who)
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic push_ev(input ev_kind_t k);
      ev_t e;
      e.kind = k;
      e.bx   = mboard(1);
      e.bo   = mboard(2);
      e.win  = m_winner;
      e.trn  = m_turn;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      for (int n = 0; n < 9; n++) cells[n] = 0;
      m_player = 0; m_moves = 0; m_waited = 0;
      m_winner = 2'b00; m_turn = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit rx, input logic [3:0] cx,
                             input bit ro, input logic [3:0] co);
      bit rq;
      int cel;
      bit free;
      if (st) begin
         for (int n = 0; n < 9; n++) cells[n] = 0;
         m_moves = 0; m_winner = 2'b00; m_waited = 0;
         m_player = FIRST; m_turn = 1'(FIRST); m_mode = M_PLAY;
      end else begin
         case (m_mode)
            M_PLAY: begin
               rq   = (m_player == 1) ? ro : rx;
               cel  = (m_player == 1) ? int'(co) : int'(cx);
               free = (cel <= 8) ? (cells[cel] == 0) : 1'b0;
               if (rq && free) begin
                  cells[cel] = m_player + 1;
                  m_moves++;
                  m_mode = M_EVAL;
                  push_ev((m_player == 1) ? EV_GO : EV_GX);
               end else if (TO_CYC > 0 && m_waited == TO_CYC - 1) begin
                  m_player = 1 - m_player; m_turn = 1'(m_player); m_waited = 0;
                  push_ev(EV_TO);
               end else begin
                  if (rq) push_ev(EV_REJ);
                  m_waited++;
               end
            end
            M_EVAL: begin
               if (mwins(m_player + 1)) begin
                  m_winner = (m_player == 1) ? 2'b10 : 2'b01;
                  m_mode = M_DONE;
                  push_ev(EV_END);
               end else if (m_moves == 9) begin
                  m_winner = 2'b11;
                  m_mode = M_DONE;
                  push_ev(EV_END);
               end else begin
                  m_player = 1 - m_player; m_turn = 1'(m_player); m_waited = 0;
                  m_mode = M_PLAY;
               end
            end
            default: begin
            end
         endcase
      end
   endtask

   task automatic snapshot();
      chk("board_x", 32'(board_x), 32'(mboard(1)));
      chk("board_o", 32'(board_o), 32'(mboard(2)));
      chk("winner", 32'(winner), 32'(m_winner));
      chk("game_over", 32'(game_over), 32'(m_mode == M_DONE));
      chk("turn", 32'(turn), 32'(m_turn));
   endtask

   // One clock cycle: compare the visible state, then drive inputs for the next edge.
   task automatic tick(input bit rs, input bit st, input bit rx, input logic [3:0] cx,
                       input bit ro, input logic [3:0] co);
      @(negedge clk);
      snapshot();
      reset = rs; start = st; req_x = rx; cell_x = cx; req_o = ro; cell_o = co;
      if (rs) model_reset();
      else    model_step(st, rx, cx, ro, co);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(0, 0, 0, 4'd0, 0, 4'd0);
   endtask

   // A move request for one cycle, then one cycle for the line check.
   task automatic mv(input bit is_o, input int c);
      if (is_o) tick(0, 0, 0, 4'd0, 1, 4'(c));
      else      tick(0, 0, 1, 4'(c), 0, 4'd0);
      idle(1);
   endtask

   task automatic play(input int seq[]);
      for (int i = 0; i < seq.size(); i++) mv(i[0], seq[i]);
   endtask

   task automatic pop_cmp(input ev_kind_t k);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", 32'(k), 32'(e.kind));
         chk("ev_board_x", 32'(board_x), 32'(e.bx));
         chk("ev_board_o", 32'(board_o), 32'(e.bo));
         chk("ev_winner", 32'(winner), 32'(e.win));
         chk("ev_turn", 32'(turn), 32'(e.trn));
         $display("[TB] event kind=%0d bx=%03h bo=%03h win=%0d turn=%0d t=%0t",
                  k, board_x, board_o, winner, turn, $time);
      end
   endtask

   // Monitor: any pulse or a rising game_over is an output event.
   initial begin
      logic prev_go;
      int np;
      ev_kind_t k;
      prev_go = 1'b0;
      forever begin
         @(negedge clk);
         np = int'(grant_x === 1'b1) + int'(grant_o === 1'b1) + int'(reject === 1'b1) + int'(timeout === 1'b1);
         if (np > 1) chk("pulse_onehot", 32'(np), 32'd1);
         if (np >= 1) begin
            if (grant_x)      k = EV_GX;
            else if (grant_o) k = EV_GO;
            else if (reject)  k = EV_REJ;
            else              k = EV_TO;
            pop_cmp(k);
         end
         if (game_over === 1'b1 && !prev_go) pop_cmp(EV_END);
         prev_go = (game_over === 1'b1);
      end
   end

   initial begin
      int draw_seq[];
      int win9_seq[];
      int win_seq[];
      bit rs, st, rx, ro;
      logic [3:0] cx, co;

      reset = 1'b1; start = 1'b0; req_x = 1'b0; req_o = 1'b0; cell_x = 4'd0; cell_o = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);

      // Reset state and first move.
      @(negedge clk);
      chk("rst_grant_x", 32'(grant_x), 32'd0);
      chk("rst_grant_o", 32'(grant_o), 32'd0);
      chk("rst_reject", 32'(reject), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      idle(1);
      tick(0, 1, 0, 4'd0, 0, 4'd0);
      mv(0, 4);
      idle(2);

      // X wins along the top row; later requests ignored.
      win_seq = '{0, 3, 1, 4, 2};
      tick(0, 1, 0, 4'd0, 0, 4'd0);
      play(win_seq);
      repeat (4) tick(0, 0, 1, 4'd5, 1, 4'd6);

      // Rejects in TURN_O: occupied cell and out-of-range cell.
      tick(0, 1, 0, 4'd0, 0, 4'd0);
      mv(0, 4);
      tick(0, 0, 0, 4'd0, 1, 4'd4);
      tick(0, 0, 0, 4'd0, 1, 4'd9);
      tick(0, 0, 1, 4'd2, 0, 4'd0);
      mv(1, 0);

      // Draw on the 9th move, then a 9th move that completes a line.
      draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      tick(0, 1, 0, 4'd0, 0, 4'd0);
      play(draw_seq);
      idle(2);
      win9_seq = '{0, 1, 2, 4, 3, 5, 7, 8, 6};
      tick(0, 1, 0, 4'd0, 0, 4'd0);
      play(win9_seq);
      idle(2);

      // Timeout after 8 idle cycles; legal request on the 8th cycle wins instead.
      tick(0, 1, 0, 4'd0, 0, 4'd0);
      idle(10);
      tick(0, 1, 0, 4'd0, 0, 4'd0);
      idle(7);
      tick(0, 0, 1, 4'd8, 0, 4'd0);
      idle(3);

      // start beats a same-cycle request; reset during CHECK.
      tick(0, 0, 0, 4'd0, 1, 4'd0);
      tick(0, 1, 1, 4'd3, 0, 4'd0);
      idle(1);
      tick(0, 0, 1, 4'd7, 0, 4'd0);
      tick(1, 0, 0, 4'd0, 0, 4'd0);
      @(posedge clk); #1;
      chk("rstchk_grant_x", 32'(grant_x), 32'd0);
      chk("rstchk_game_over", 32'(game_over), 32'd0);
      tick(0, 0, 1, 4'd1, 1, 4'd2);
      idle(2);

      // Random play.
      for (int i = 0; i < 4000; i++) begin
         rs = ($urandom_range(0, 499) == 0);
         if (m_mode == M_DONE || m_mode == M_IDLE) st = ($urandom_range(0, 3) == 0);
         else                                      st = ($urandom_range(0, 199) == 0);
         rx = ($urandom_range(0, 3) == 0);
         ro = ($urandom_range(0, 3) == 0);
         cx = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         co = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         tick(rs, st, rx, cx, ro, co);
      end

      idle(4);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
